// File: rtl/serial_addsub_pkg.sv
// Shared types and helpers for the bit-serial add/subtract stage.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_W = 3;

  // Signed overflow: operands agree in sign but the sum does not.
  function automatic logic add_ovf(input logic a_msb, input logic c_msb, input logic s_msb);
    return (a_msb == c_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Start/busy/done handshake and operand/result bus for serial_addsub.
interface serial_addsub_if
  import serial_addsub_pkg::*;
#(
  parameter int W = DEFAULT_W
);

  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] c_in;
  logic         op_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         op_out;

  modport master (
    output start, a_in, c_in, op_in,
    input  busy, done, sum, cout, ovf, op_out
  );

  modport slave (
    input  start, a_in, c_in, op_in,
    output busy, done, sum, cout, ovf, op_out
  );

endinterface

// File: rtl/serial_addsub_full_adder.sv
// One-bit full adder used as the serial datapath core.
module full_adder
  import serial_addsub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial A + C, LSB first, one bit per clock; the result is committed
// atomically at the end so the outputs never show partial sums.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic             clk,
  input  logic             rst,
  serial_addsub_if.slave   bus
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t        state;
  state_t        state_next;
  logic          start_acc;

  logic [W-1:0]  a_reg;
  logic [W-1:0]  c_reg;
  logic [W-1:0]  res;
  logic [W-1:0]  res_next;
  logic          carry;
  logic          op_reg;
  logic [CW-1:0] cnt;
  logic          last;

  logic          fa_s;
  logic          fa_co;

  assign last     = (cnt == LAST);
  assign res_next = {fa_s, res[W-1:1]};

  full_adder u_fa (
    .a  (a_reg[cnt]),
    .b  (c_reg[cnt]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Next-state logic; start is honoured only outside RUN.
  always_comb begin
    state_next = state;
    start_acc  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          start_acc  = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        if (bus.start) begin
          start_acc  = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register plus registered busy/done decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state    <= state_next;
      bus.busy <= (state_next == RUN);
      bus.done <= (state_next == DONE);
    end
  end

  // Operand capture, serial accumulation and result commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg      <= '0;
      c_reg      <= '0;
      res        <= '0;
      carry      <= 1'b0;
      op_reg     <= 1'b0;
      cnt        <= '0;
      bus.sum    <= '0;
      bus.cout   <= 1'b0;
      bus.ovf    <= 1'b0;
      bus.op_out <= 1'b0;
    end else if (start_acc) begin
      a_reg  <= bus.a_in;
      c_reg  <= bus.c_in;
      op_reg <= bus.op_in;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (state == RUN) begin
      res   <= res_next;
      carry <= fa_co;
      cnt   <= cnt + CW'(1);
      if (last) begin
        bus.sum    <= res_next;
        bus.cout   <= fa_co;
        bus.ovf    <= add_ovf(a_reg[W-1], c_reg[W-1], fa_s);
        bus.op_out <= op_reg;
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub with W=3.
module tb_serial_addsub;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  serial_addsub_if #(.W(3)) bus ();

  serial_addsub #(.W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [2:0] a, input logic [2:0] c,
                        input logic op, input logic [2:0] es, input logic ec,
                        input logic eo, input logic eop);
    int lat;
    int bcnt;
    logic [2:0] prev;
    prev = bus.sum;
    bus.start = 1'b1;
    bus.a_in  = a;
    bus.c_in  = c;
    bus.op_in = op;
    step();
    bus.start = 1'b0;
    bus.a_in  = ~a;
    bus.c_in  = ~c;
    bus.op_in = ~op;
    lat  = 0;
    bcnt = 0;
    while (!bus.done && lat < 10) begin
      if (bus.busy) bcnt++;
      check({tag, "_sum_held"}, 32'(bus.sum), 32'(prev));
      step();
      lat++;
    end
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'd3);
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'd3);
    check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
    check({tag, "_sum"}, 32'(bus.sum), 32'(es));
    check({tag, "_cout"}, 32'(bus.cout), 32'(ec));
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
    check({tag, "_op_out"}, 32'(bus.op_out), 32'(eop));
    step();
    check({tag, "_done_pulse_end"}, 32'(bus.done), 32'd0);
    check({tag, "_sum_hold_idle"}, 32'(bus.sum), 32'(es));
  endtask

  initial begin
    int dcnt;
    int done_at;
    int n;
    int t1;
    int t2;
    logic [2:0] s1;
    logic [2:0] s2;
    logic busy4;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.c_in  = '0;
    bus.op_in = 1'b0;

    // Reset state
    #2;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    check("rst_op_out", 32'(bus.op_out), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // Directed operations
    run_op("op1", 3'b011, 3'b001, 1'b0, 3'b100, 1'b0, 1'b1, 1'b0);
    run_op("op2", 3'b010, 3'b111, 1'b1, 3'b001, 1'b1, 1'b0, 1'b1);
    run_op("op3", 3'b101, 3'b110, 1'b0, 3'b011, 1'b1, 1'b1, 1'b0);
    run_op("op4", 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);

    // Start during RUN must be ignored
    bus.start = 1'b1;
    bus.a_in  = 3'b011;
    bus.c_in  = 3'b001;
    bus.op_in = 1'b0;
    step();
    bus.a_in  = 3'b111;
    bus.c_in  = 3'b111;
    bus.op_in = 1'b1;
    step();
    bus.start = 1'b0;
    dcnt = 0;
    done_at = 0;
    for (int i = 2; i <= 9; i++) begin
      step();
      if (bus.done) begin
        dcnt++;
        done_at = i;
      end
    end
    check("ign_done_count", 32'(dcnt), 32'd1);
    check("ign_done_at", 32'(done_at), 32'd3);
    check("ign_sum", 32'(bus.sum), 32'(3'b100));
    check("ign_cout", 32'(bus.cout), 32'd0);
    check("ign_ovf", 32'(bus.ovf), 32'd1);
    check("ign_op_out", 32'(bus.op_out), 32'd0);

    // Asynchronous reset mid-RUN
    bus.start = 1'b1;
    bus.a_in  = 3'b101;
    bus.c_in  = 3'b110;
    bus.op_in = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    check("abort_busy_before", 32'(bus.busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_sum", 32'(bus.sum), 32'd0);
    check("abort_cout", 32'(bus.cout), 32'd0);
    check("abort_ovf", 32'(bus.ovf), 32'd0);
    check("abort_op_out", 32'(bus.op_out), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("abort_no_done", 32'(bus.done), 32'd0);
    run_op("fresh", 3'b010, 3'b111, 1'b1, 3'b001, 1'b1, 1'b0, 1'b1);

    // Back-to-back with start held high
    bus.start = 1'b1;
    bus.a_in  = 3'b011;
    bus.c_in  = 3'b001;
    bus.op_in = 1'b0;
    step();
    bus.a_in  = 3'b001;
    bus.c_in  = 3'b001;
    n = 0;
    t1 = 0;
    t2 = 0;
    s1 = '0;
    s2 = '0;
    busy4 = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      step();
      if (bus.done) begin
        n++;
        if (n == 1) begin
          t1 = cyc;
          s1 = bus.sum;
        end else begin
          t2 = cyc;
          s2 = bus.sum;
        end
      end
      if (cyc == 4) busy4 = bus.busy;
      if (cyc == 7) bus.start = 1'b0;
    end
    check("b2b_done_count", 32'(n), 32'd2);
    check("b2b_first_at", 32'(t1), 32'd3);
    check("b2b_spacing", 32'(t2 - t1), 32'd4);
    check("b2b_sum1", 32'(s1), 32'(3'b100));
    check("b2b_sum2", 32'(s2), 32'(3'b010));
    check("b2b_no_idle", 32'(busy4), 32'd1);
    check("b2b_cout2", 32'(bus.cout), 32'd0);
    check("b2b_ovf2", 32'(bus.ovf), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
